// File: rtl/imm_prefix_extender_pkg.sv
// -----------------------------------------------------------------------------
// imm_prefix_extender_pkg
// Shared definitions for the prefix-based immediate extender.
//   IMM_W_DEF / DATA_W_DEF : default field and datapath widths
//   EXT_MODE_W             : width of the extension-mode selector
//   ext_mode_e             : extension modes (encoding 2'b11 behaves as ZERO)
//   field_width()          : combined field width for a given prefix count
// -----------------------------------------------------------------------------
package imm_prefix_extender_pkg;

    localparam int IMM_W_DEF   = 8;
    localparam int DATA_W_DEF  = 16;
    localparam int MAX_PFX_DEF = 1;
    localparam int EXT_MODE_W  = 2;

    typedef enum logic [EXT_MODE_W-1:0] {
        EXT_ZERO = 2'b00,
        EXT_SIGN = 2'b01,
        EXT_HIGH = 2'b10
    } ext_mode_e;

    // Width of the field formed by cnt prefixes plus the final field,
    // clamped to the datapath width.
    function automatic int field_width(input int cnt, input int imm_w, input int data_w);
        int w;
        w = (cnt + 1) * imm_w;
        return (w > data_w) ? data_w : w;
    endfunction

endpackage

// File: rtl/imm_prefix_extender_var_extender.sv
// -----------------------------------------------------------------------------
// imm_prefix_extender_var_extender
// Combinational extender with a runtime field width.
//   field_i  [DATA_W-1:0] : right-aligned field; only bits below fw_i count
//   fw_i     [FW_W-1:0]   : number of valid field bits (1..DATA_W)
//   mode_i   [1:0]        : ZERO / SIGN / HIGH (2'b11 behaves as ZERO)
//   result_o [DATA_W-1:0] : extended value
// -----------------------------------------------------------------------------
module imm_prefix_extender_var_extender
    import imm_prefix_extender_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int FW_W   = $clog2(DATA_W + 1)
) (
    input  logic [DATA_W-1:0]     field_i,
    input  logic [FW_W-1:0]       fw_i,
    input  logic [EXT_MODE_W-1:0] mode_i,
    output logic [DATA_W-1:0]     result_o
);

    logic [DATA_W-1:0] keep;
    logic [DATA_W-1:0] masked;
    logic [FW_W-1:0]   shamt;
    logic              sign_bit;

    // keep marks the valid field bits; sign_bit is the field's top valid bit.
    always_comb begin
        keep     = '0;
        sign_bit = 1'b0;
        for (int i = 0; i < DATA_W; i++) begin
            if (i < int'(fw_i)) begin
                keep[i] = 1'b1;
            end
            if (i == int'(fw_i) - 1) begin
                sign_bit = field_i[i];
            end
        end
    end

    assign masked = field_i & keep;
    assign shamt  = FW_W'(DATA_W) - fw_i;

    always_comb begin
        result_o = masked;
        case (mode_i)
            EXT_SIGN: result_o = sign_bit ? (masked | ~keep) : masked;
            EXT_HIGH: result_o = masked << shamt;
            default:  result_o = masked;
        endcase
    end

endmodule

// File: rtl/imm_prefix_extender.sv
// -----------------------------------------------------------------------------
// imm_prefix_extender
// Sequential immediate builder at the decode/execute boundary. PREFIX
// instructions shift IMM_W bits each into an accumulator; the next non-prefix
// instruction supplies the final field, and the combined value is extended and
// registered.
//   clk_i          : clock, rising edge
//   rst_i          : synchronous active-high reset
//   en_i           : pipeline advance (0 = stall, state holds)
//   flush_i        : discard pending prefixes (wins over en_i)
//   instr_vld_i    : instruction fields are valid
//   prefix_i       : instruction is a prefix
//   mode_i         : extension mode
//   imm_in_i       : immediate field
//   imm_out_o      : registered extended immediate
//   imm_vld_o      : one-cycle pulse, imm_out_o updated
//   pfx_pending_o  : at least one prefix held
//   pfx_ovf_o      : one-cycle pulse, prefix rejected (limit reached)
// -----------------------------------------------------------------------------
module imm_prefix_extender
    import imm_prefix_extender_pkg::*;
#(
    parameter int IMM_W   = IMM_W_DEF,
    parameter int DATA_W  = DATA_W_DEF,
    parameter int MAX_PFX = MAX_PFX_DEF
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  en_i,
    input  logic                  flush_i,
    input  logic                  instr_vld_i,
    input  logic                  prefix_i,
    input  logic [EXT_MODE_W-1:0] mode_i,
    input  logic [IMM_W-1:0]      imm_in_i,
    output logic [DATA_W-1:0]     imm_out_o,
    output logic                  imm_vld_o,
    output logic                  pfx_pending_o,
    output logic                  pfx_ovf_o
);

    localparam int CNT_W = $clog2(MAX_PFX + 1);
    localparam int FW_W  = $clog2(DATA_W + 1);

    logic [DATA_W-1:0] acc_q, acc_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [DATA_W-1:0] imm_out_q, imm_out_d;
    logic              imm_vld_q, imm_vld_d;
    logic              pfx_ovf_q, pfx_ovf_d;

    logic [DATA_W-1:0] field_cat;
    logic [FW_W-1:0]   field_w;
    logic [DATA_W-1:0] ext_result;

    // {acc, imm_in} truncated to DATA_W; used both to accumulate a prefix
    // and as the final combined field.
    assign field_cat = DATA_W'({acc_q, imm_in_i});
    assign field_w   = FW_W'(field_width(int'(cnt_q), IMM_W, DATA_W));

    imm_prefix_extender_var_extender #(
        .DATA_W (DATA_W),
        .FW_W   (FW_W)
    ) u_var_extender (
        .field_i  (field_cat),
        .fw_i     (field_w),
        .mode_i   (mode_i),
        .result_o (ext_result)
    );

    // Priority: flush > stall > instruction. Pulses default low every cycle.
    always_comb begin
        acc_d     = acc_q;
        cnt_d     = cnt_q;
        imm_out_d = imm_out_q;
        imm_vld_d = 1'b0;
        pfx_ovf_d = 1'b0;
        if (flush_i) begin
            acc_d = '0;
            cnt_d = '0;
        end else if (en_i && instr_vld_i) begin
            if (prefix_i) begin
                if (cnt_q < CNT_W'(MAX_PFX)) begin
                    acc_d = field_cat;
                    cnt_d = cnt_q + CNT_W'(1);
                end else begin
                    pfx_ovf_d = 1'b1;
                end
            end else begin
                imm_out_d = ext_result;
                imm_vld_d = 1'b1;
                acc_d     = '0;
                cnt_d     = '0;
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            acc_q     <= '0;
            cnt_q     <= '0;
            imm_out_q <= '0;
            imm_vld_q <= 1'b0;
            pfx_ovf_q <= 1'b0;
        end else begin
            acc_q     <= acc_d;
            cnt_q     <= cnt_d;
            imm_out_q <= imm_out_d;
            imm_vld_q <= imm_vld_d;
            pfx_ovf_q <= pfx_ovf_d;
        end
    end

    assign imm_out_o     = imm_out_q;
    assign imm_vld_o     = imm_vld_q;
    assign pfx_ovf_o     = pfx_ovf_q;
    assign pfx_pending_o = (cnt_q != '0);

endmodule

// File: tb/tb_imm_prefix_extender.sv
module tb_imm_prefix_extender;
    import imm_prefix_extender_pkg::*;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    // Default-parameter DUT (IMM_W=8, DATA_W=16, MAX_PFX=1)
    logic        rst, en, flush, vld, pfx;
    logic [1:0]  mode;
    logic [7:0]  imm;
    logic [15:0] imm_out;
    logic        imm_vld, pending, ovf;

    imm_prefix_extender dut (
        .clk_i         (clk),
        .rst_i         (rst),
        .en_i          (en),
        .flush_i       (flush),
        .instr_vld_i   (vld),
        .prefix_i      (pfx),
        .mode_i        (mode),
        .imm_in_i      (imm),
        .imm_out_o     (imm_out),
        .imm_vld_o     (imm_vld),
        .pfx_pending_o (pending),
        .pfx_ovf_o     (ovf)
    );

    // IMM_W=4, DATA_W=16, MAX_PFX=3
    logic        rst4, en4, flush4, vld4, pfx4;
    logic [1:0]  mode4;
    logic [3:0]  imm4;
    logic [15:0] imm_out4;
    logic        imm_vld4, pending4, ovf4;

    imm_prefix_extender #(.IMM_W(4), .DATA_W(16), .MAX_PFX(3)) dut4 (
        .clk_i         (clk),
        .rst_i         (rst4),
        .en_i          (en4),
        .flush_i       (flush4),
        .instr_vld_i   (vld4),
        .prefix_i      (pfx4),
        .mode_i        (mode4),
        .imm_in_i      (imm4),
        .imm_out_o     (imm_out4),
        .imm_vld_o     (imm_vld4),
        .pfx_pending_o (pending4),
        .pfx_ovf_o     (ovf4)
    );

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Drive one cycle on the default DUT, sample 1 time unit after the edge.
    task automatic step(input logic r, input logic e, input logic f, input logic v,
                        input logic p, input logic [1:0] m, input logic [7:0] d);
        rst = r; en = e; flush = f; vld = v; pfx = p; mode = m; imm = d;
        @(posedge clk);
        #1;
    endtask

    task automatic step4(input logic v, input logic p, input logic [1:0] m,
                         input logic [3:0] d);
        rst4 = 1'b0; en4 = 1'b1; flush4 = 1'b0; vld4 = v; pfx4 = p; mode4 = m; imm4 = d;
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst = 1'b1; en = 1'b0; flush = 1'b0; vld = 1'b0; pfx = 1'b0; mode = 2'b00; imm = 8'h00;
        rst4 = 1'b1; en4 = 1'b0; flush4 = 1'b0; vld4 = 1'b0; pfx4 = 1'b0; mode4 = 2'b00; imm4 = 4'h0;
        #1;

        // 1 Reset with random inputs for 2 clocks
        for (int i = 0; i < 2; i++) begin
            step(1'b1, 1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom),
                 2'($urandom), 8'($urandom));
        end
        chk("rst_imm_out", imm_out, 16'h0000);
        chk("rst_imm_vld", {15'd0, imm_vld}, 16'h0000);
        chk("rst_pending", {15'd0, pending}, 16'h0000);
        chk("rst_ovf",     {15'd0, ovf},     16'h0000);
        rst4 = 1'b0;

        // 2 No prefix, 8'h80
        step(0, 1, 0, 1, 0, EXT_SIGN, 8'h80);
        chk("sign80_out", imm_out, 16'hFF80);
        chk("sign80_vld", {15'd0, imm_vld}, 16'h0001);
        step(0, 1, 0, 0, 0, EXT_ZERO, 8'h00);
        chk("sign80_vld_drop", {15'd0, imm_vld}, 16'h0000);
        chk("sign80_hold", imm_out, 16'hFF80);
        step(0, 1, 0, 1, 0, EXT_ZERO, 8'h80);
        chk("zero80_out", imm_out, 16'h0080);
        chk("zero80_vld", {15'd0, imm_vld}, 16'h0001);
        step(0, 1, 0, 1, 0, EXT_HIGH, 8'h80);
        chk("high80_out", imm_out, 16'h8000);
        step(0, 1, 0, 0, 0, EXT_ZERO, 8'h00);
        chk("high80_vld_drop", {15'd0, imm_vld}, 16'h0000);
        step(0, 1, 0, 1, 0, 2'b11, 8'h80);
        chk("mode11_out", imm_out, 16'h0080);

        // 3 Prefix sequences
        step(0, 1, 0, 1, 1, EXT_SIGN, 8'h12);
        chk("pfx12_pending", {15'd0, pending}, 16'h0001);
        chk("pfx12_novld", {15'd0, imm_vld}, 16'h0000);
        step(0, 1, 0, 1, 0, EXT_SIGN, 8'h34);
        chk("f1234_out", imm_out, 16'h1234);
        chk("f1234_pending", {15'd0, pending}, 16'h0000);
        chk("f1234_vld", {15'd0, imm_vld}, 16'h0001);
        step(0, 1, 0, 1, 1, EXT_ZERO, 8'hFF);
        step(0, 1, 0, 1, 0, EXT_ZERO, 8'h80);
        chk("fff80_out", imm_out, 16'hFF80);

        // 4 Overflow
        step(0, 1, 0, 1, 1, EXT_ZERO, 8'h12);
        chk("ovf_first_clear", {15'd0, ovf}, 16'h0000);
        step(0, 1, 0, 1, 1, EXT_ZERO, 8'h56);
        chk("ovf_second_set", {15'd0, ovf}, 16'h0001);
        chk("ovf_pending", {15'd0, pending}, 16'h0001);
        step(0, 1, 0, 1, 0, EXT_ZERO, 8'h34);
        chk("ovf_final_out", imm_out, 16'h1234);
        chk("ovf_pulse_drop", {15'd0, ovf}, 16'h0000);

        // 5 Flush / stall / reset
        step(0, 1, 0, 1, 1, EXT_ZERO, 8'h12);
        step(0, 1, 1, 1, 0, EXT_SIGN, 8'h99);
        chk("flush_pending", {15'd0, pending}, 16'h0000);
        chk("flush_novld", {15'd0, imm_vld}, 16'h0000);
        chk("flush_hold", imm_out, 16'h1234);
        step(0, 1, 0, 1, 0, EXT_ZERO, 8'h34);
        chk("postflush_out", imm_out, 16'h0034);
        step(0, 0, 0, 1, 1, EXT_ZERO, 8'h12);
        chk("stall_pfx_ignored", {15'd0, pending}, 16'h0000);
        step(0, 1, 0, 1, 0, EXT_SIGN, 8'h34);
        chk("stall_pfx_final", imm_out, 16'h0034);
        step(0, 1, 0, 1, 1, EXT_ZERO, 8'h12);
        step(0, 0, 0, 1, 0, EXT_SIGN, 8'h34);
        chk("stall_novld", {15'd0, imm_vld}, 16'h0000);
        chk("stall_keep_pending", {15'd0, pending}, 16'h0001);
        chk("stall_hold_out", imm_out, 16'h0034);
        step(0, 1, 0, 1, 0, EXT_SIGN, 8'h34);
        chk("unstall_final", imm_out, 16'h1234);
        step(0, 1, 0, 1, 1, EXT_ZERO, 8'h12);
        step(1, 1, 0, 0, 0, EXT_ZERO, 8'h00);
        chk("rstpfx_pending", {15'd0, pending}, 16'h0000);
        chk("rstpfx_out", imm_out, 16'h0000);
        step(0, 1, 0, 1, 0, EXT_SIGN, 8'h34);
        chk("rstpfx_final", imm_out, 16'h0034);
        step(0, 1, 0, 0, 0, EXT_ZERO, 8'h00);

        // 6 IMM_W=4, MAX_PFX=3
        step4(1, 1, EXT_SIGN, 4'hA);
        step4(1, 1, EXT_SIGN, 4'hB);
        step4(1, 1, EXT_SIGN, 4'hC);
        chk("w4_pending", {15'd0, pending4}, 16'h0001);
        step4(1, 1, EXT_SIGN, 4'hE);
        chk("w4_ovf", {15'd0, ovf4}, 16'h0001);
        step4(1, 0, EXT_SIGN, 4'hD);
        chk("w4_abcd", imm_out4, 16'hABCD);
        chk("w4_abcd_vld", {15'd0, imm_vld4}, 16'h0001);
        step4(1, 0, EXT_SIGN, 4'h8);
        chk("w4_sign8", imm_out4, 16'hFFF8);
        step4(1, 0, EXT_HIGH, 4'h8);
        chk("w4_high8", imm_out4, 16'h8000);
        step4(1, 1, EXT_HIGH, 4'h1);
        step4(1, 1, EXT_HIGH, 4'h2);
        step4(1, 0, EXT_HIGH, 4'h3);
        chk("w4_high123", imm_out4, 16'h1230);
        step4(1, 1, EXT_SIGN, 4'h8);
        step4(1, 0, EXT_SIGN, 4'h0);
        chk("w4_sign80", imm_out4, 16'hFF80);
        step4(1, 1, EXT_ZERO, 4'h8);
        step4(1, 0, EXT_ZERO, 4'h0);
        chk("w4_zero80", imm_out4, 16'h0080);
        step4(0, 0, EXT_ZERO, 4'h0);
        chk("w4_vld_drop", {15'd0, imm_vld4}, 16'h0000);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
